// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Board divisors assume a 100 MHz reference clock.
package clkdiv_pkg;
  localparam int DIV_1HZ       = 50_000_000;
  localparam int DIV_MUX_1KHZ  = 50_000;
  localparam int DIV_BLINK_2HZ = 25_000_000;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: counter, shadow divisor with pending flag, tick and square wave.
// Optional macro CLKDIV_STATUS_EN exposes the pending flag as an output.
module clock_divider_ch #(
  parameter int CNT_W   = 27,
  parameter int DEF_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
`ifdef CLKDIV_STATUS_EN
  output logic             pend,
`endif
  output logic             tick,
  output logic             clk_out
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic             pend_q, pend_d, tick_q, tick_d, clk_q, clk_d;
  logic             terminal;

  assign terminal = (cnt_q == act_q - ONE);

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    clk_d  = clk_q;
    if (sync_clr) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      if (wr) begin
        act_d = wr_div;
        shd_d = wr_div;
      end else if (pend_q) begin
        act_d = shd_q;
      end
    end else if (act_q == '0) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (wr) begin
        act_d = wr_div;
        shd_d = wr_div;
      end
    end else if (en && terminal) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      clk_d  = ~clk_q;
      pend_d = 1'b0;
      // A write landing on the terminal edge beats whatever is in the shadow.
      if (wr) begin
        act_d = wr_div;
        shd_d = wr_div;
      end else if (pend_q) begin
        act_d = shd_q;
      end
    end else begin
      if (en) cnt_d = cnt_q + ONE;
      if (wr) begin
        shd_d  = wr_div;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= DEF;
      shd_q  <= DEF;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_q;
`ifdef CLKDIV_STATUS_EN
  assign pend    = pend_q;
`endif
endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable divider / tick generator.
// Optional macro CLKDIV_STATUS_EN adds the per-channel pending output.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 27,
  parameter int DEF_DIV = DIV_1HZ,
  parameter int CH_W    = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef CLKDIV_STATUS_EN
  output logic [NUM_CH-1:0] pending,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);
  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range channel numbers match no channel and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr_sel[i] = wr_en && (wr_ch == CH_W'(i));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divider_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync_clr (sync_clr),
      .wr       (wr_sel[g]),
      .wr_div   (wr_div),
`ifdef CLKDIV_STATUS_EN
      .pend     (pending[g]),
`endif
      .tick     (tick[g]),
      .clk_out  (clk_out[g])
    );
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: period-level reference model, directed scenarios, random phase.
module tb_prog_clock_divider;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, sync_clr = 1'b0, wr_en = 1'b0, wr_en3 = 1'b0;
  logic       wr_ch = 1'b0;
  logic [1:0] wr_ch3 = 2'd3;
  logic [7:0] wr_div = 8'd0;
  logic [1:0] tick, clk_out;
  logic [2:0] tick3, clk3;
`ifdef CLKDIV_STATUS_EN
  logic [1:0] pend_w;
  logic [2:0] pend3_w;
`endif

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  prog_clock_divider #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef CLKDIV_STATUS_EN
    .pending(pend_w),
`endif
    .tick(tick), .clk_out(clk_out));

  // Three-channel copy so an out-of-range select (3) is representable.
  prog_clock_divider #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(4)) dut3 (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .wr_en(wr_en3),
    .wr_ch(wr_ch3), .wr_div(wr_div),
`ifdef CLKDIV_STATUS_EN
    .pending(pend3_w),
`endif
    .tick(tick3), .clk_out(clk3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each channel tracks enabled edges elapsed in the current period,
  // its live divisor and an optional queued divisor (-1 = none).
  int       m_n[2], m_div[2], m_nxt[2];
  bit [1:0] m_tick = 2'b00, m_lvl = 2'b00;
  bit       mw;
  int       md;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_n[c] = 0; m_div[c] = 4; m_nxt[c] = -1;
      end
      m_tick = 2'b00; m_lvl = 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        mw = wr_en && (int'(wr_ch) == c);
        md = int'(wr_div);
        m_tick[c] = 1'b0;
        if (sync_clr) begin
          m_n[c] = 0; m_lvl[c] = 1'b0;
          if (mw) m_div[c] = md;
          else if (m_nxt[c] >= 0) m_div[c] = m_nxt[c];
          m_nxt[c] = -1;
        end else if (m_div[c] == 0) begin
          m_n[c] = 0; m_lvl[c] = 1'b0;
          if (mw) m_div[c] = md;
        end else if (en && (m_n[c] + 1 == m_div[c])) begin
          m_n[c] = 0; m_tick[c] = 1'b1; m_lvl[c] = ~m_lvl[c];
          if (mw) m_div[c] = md;
          else if (m_nxt[c] >= 0) m_div[c] = m_nxt[c];
          m_nxt[c] = -1;
        end else begin
          if (en) m_n[c] = m_n[c] + 1;
          if (mw) m_nxt[c] = md;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_tick", {30'd0, tick}, {30'd0, m_tick});
    chk("model_clk_out", {30'd0, clk_out}, {30'd0, m_lvl});
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_tick", {30'd0, tick}, 32'd0);
    chk("reset_clk_out", {30'd0, clk_out}, 32'd0);
    reset = 1'b0; en = 1'b1;

    // Default divisor 4: tick at edges 4 and 8, clk_out up at 4, down at 8.
    repeat (3) @(negedge clk);
    chk("first_tick_early", {30'd0, tick}, 32'd0);
    @(negedge clk);
    chk("first_tick", {30'd0, tick}, 32'h3);
    chk("first_rise", {30'd0, clk_out}, 32'h3);
    repeat (4) @(negedge clk);
    chk("second_tick", {30'd0, tick}, 32'h3);
    chk("first_fall", {30'd0, clk_out}, 32'h0);

    // Edge 9 done (cnt=1): queue D=2 on ch1, current period still completes.
    @(negedge clk);
    wr_en = 1'b1; wr_ch = 1'b1; wr_div = 8'd2;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_period_completes", {30'd0, tick}, 32'h3);
    @(negedge clk);
    chk("wr_gap", {30'd0, tick}, 32'h0);
    @(negedge clk);
    chk("wr_new_div", {30'd0, tick}, 32'h2);

    // Queue D=3/D=5, then sync_clr applies both: common tick 15 edges on.
    wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd3;
    @(negedge clk); wr_ch = 1'b1; wr_div = 8'd5;
    @(negedge clk); wr_en = 1'b0; sync_clr = 1'b1;
    @(negedge clk); sync_clr = 1'b0;
    chk("clr_outputs", {30'd0, clk_out}, 32'h0);
    repeat (14) @(negedge clk);
    chk("clr_not_yet", {30'd0, tick}, 32'h0);
    @(negedge clk);
    chk("clr_aligned", {30'd0, tick}, 32'h3);

    // Halt ch0 with D=0, then restart with D=3.
    wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd0;
    @(negedge clk); wr_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("halt_clk_out0", {31'd0, clk_out[0]}, 32'd0);
    chk("halt_tick0", {31'd0, tick[0]}, 32'd0);
    wr_en = 1'b1; wr_div = 8'd3;
    @(negedge clk); wr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("restart_early", {31'd0, tick[0]}, 32'd0);
    @(negedge clk);
    chk("restart_tick", {31'd0, tick[0]}, 32'd1);

    // Asynchronous reset between edges clears outputs at once.
    #2 reset = 1'b1;
    #1;
    chk("async_reset_tick", {30'd0, tick}, 32'd0);
    chk("async_reset_clk", {30'd0, clk_out}, 32'd0);
    @(negedge clk); reset = 1'b0;
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div = 8'd2;
    repeat (4) @(negedge clk);
    chk("rst_div_back", {30'd0, tick}, 32'h3);
    chk("bad_ch_tick4", {29'd0, tick3}, 32'h7);
    repeat (2) @(negedge clk);
    chk("bad_ch_tick6", {29'd0, tick3}, 32'h0);
    repeat (2) @(negedge clk);
    chk("bad_ch_tick8", {29'd0, tick3}, 32'h7);
    wr_en3 = 1'b0;

    // Random phase; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 149) == 0);
      wr_en    = ($urandom_range(0, 24) == 0);
      wr_ch    = 1'($urandom_range(0, 1));
      wr_div   = 8'($urandom_range(0, 6));
      @(negedge clk);
    end
    en = 1'b0; wr_en = 1'b0; sync_clr = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
